// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 8 lines x 16-byte blocks, 25-bit tag.
// Hits are served combinationally; misses stall the CPU and fill one block from instruction memory.

module icache_line (
   input  logic         clock,
   input  logic         reset,
   input  logic         we,
   input  logic [24:0]  wtag,
   input  logic [127:0] wdata,
   output logic         valid,
   output logic [24:0]  tag,
   output logic [127:0] data
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)  valid <= 1'b0;
      else if (we) valid <= 1'b1;
   end

   // Tag and data need no reset; valid alone qualifies them.
   always_ff @(posedge clock) begin
      if (we) begin
         tag  <= wtag;
         data <= wdata;
      end
   end

endmodule

module instruction_cache (
   input  logic         clock,
   input  logic         reset,
   input  logic         read,
   input  logic [31:0]  address,
   output logic [31:0]  readdata,
   output logic         busywait,
   output logic         mem_read,
   output logic [27:0]  mem_address,
   input  logic [127:0] mem_readdata,
   input  logic         mem_busywait
);

   localparam int NUM_LINES = 8;

   typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

   state_t state, state_nxt;

   logic [NUM_LINES-1:0]         valid_arr;
   logic [NUM_LINES-1:0][24:0]   tag_arr;
   logic [NUM_LINES-1:0][127:0]  data_arr;
   logic [NUM_LINES-1:0]         line_we;

   logic [2:0]  index;
   logic [1:0]  offset;
   logic        hit;
   logic        miss;
   logic        unused_bits;

   assign index       = address[6:4];
   assign offset      = address[3:2];
   assign unused_bits = ^address[1:0];

   genvar i;
   generate
      for (i = 0; i < NUM_LINES; i++) begin : g_line
         assign line_we[i] = (state == UPDATE) && (mem_address[2:0] == i);
         icache_line u_line (
            .clock (clock),
            .reset (reset),
            .we    (line_we[i]),
            .wtag  (mem_address[27:3]),
            .wdata (mem_readdata),
            .valid (valid_arr[i]),
            .tag   (tag_arr[i]),
            .data  (data_arr[i])
         );
      end
   endgenerate

   assign hit      = read && valid_arr[index] && (tag_arr[index] == address[31:7]);
   assign miss     = read && !hit;
   assign readdata = hit ? data_arr[index][{offset, 5'b0} +: 32] : 32'h0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Latch the block address only when a fill starts, so a misbehaving
   // CPU changing address mid-fill cannot corrupt the request.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                      mem_address <= 28'h0;
      else if (state == IDLE && miss)  mem_address <= address[31:4];
   end

   always_comb begin
      state_nxt = state;
      mem_read  = 1'b0;
      busywait  = 1'b0;
      case (state)
         IDLE: begin
            busywait = miss;
            if (miss) state_nxt = MEM_READ;
         end
         MEM_READ: begin
            mem_read = 1'b1;
            busywait = 1'b1;
            if (!mem_busywait) state_nxt = UPDATE;
         end
         UPDATE: begin
            busywait  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // No stall is reported to the CPU while reset is held.
      if (!reset) busywait = 1'b0;
   end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a fixed-latency instruction memory model.

module tb_instruction_cache;

   logic         clock = 1'b0;
   logic         reset;
   logic         read;
   logic [31:0]  address;
   logic [31:0]  readdata;
   logic         busywait;
   logic         mem_read;
   logic [27:0]  mem_address;
   logic [127:0] mem_readdata;
   logic         mem_busywait;

   int n_chk  = 0;
   int n_pass = 0;
   int mem_cnt = 0;

   localparam int MEM_LAT = 3;

   always #5 clock = ~clock;

   instruction_cache dut (
      .clock        (clock),
      .reset        (reset),
      .read         (read),
      .address      (address),
      .readdata     (readdata),
      .busywait     (busywait),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait)
   );

   // Block 0 holds a short program; everything else returns C0DE0000 | byte address.
   function automatic logic [31:0] memword(input logic [31:0] a);
      if (a[31:4] == 28'h0) begin
         case (a[3:2])
            2'd0:    return 32'h00500093;
            2'd1:    return 32'h00506113;
            default: return 32'h00000013;
         endcase
      end
      return 32'hC0DE0000 | a;
   endfunction

   always @(posedge clock) mem_cnt <= mem_read ? mem_cnt + 1 : 0;

   assign mem_busywait = mem_read && (mem_cnt < MEM_LAT);
   assign mem_readdata = {memword({mem_address, 4'hC}), memword({mem_address, 4'h8}),
                          memword({mem_address, 4'h4}), memword({mem_address, 4'h0})};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Issue one fetch and wait (bounded) until it is served.
   task automatic fetch(input logic [31:0] a, output int busy_n, output int mem_n,
                        output logic [27:0] maddr, output logic [31:0] data);
      @(negedge clock);
      address = a;
      read    = 1'b1;
      #1;
      busy_n = 0;
      mem_n  = 0;
      maddr  = 28'hFFFFFFF;
      while (busywait && busy_n < 100) begin
         busy_n++;
         if (mem_read) begin
            mem_n++;
            maddr = mem_address;
         end
         @(negedge clock);
         #1;
      end
      data = readdata;
   endtask

   task automatic miss_chk(input string tag, input logic [31:0] a,
                           input logic [27:0] exp_ma, input logic [31:0] exp_d);
      int b, m;
      logic [27:0] ma;
      logic [31:0] d;
      fetch(a, b, m, ma, d);
      chk({tag, "_busy"}, b, 6);
      chk({tag, "_memrd"}, m, MEM_LAT + 1);
      chk({tag, "_maddr"}, {4'h0, ma}, {4'h0, exp_ma});
      chk({tag, "_data"}, d, exp_d);
   endtask

   task automatic hit_chk(input string tag, input logic [31:0] a, input logic [31:0] exp_d);
      int b, m;
      logic [27:0] ma;
      logic [31:0] d;
      fetch(a, b, m, ma, d);
      chk({tag, "_busy"}, b, 0);
      chk({tag, "_memrd"}, m, 0);
      chk({tag, "_data"}, d, exp_d);
   endtask

   initial begin
      int mr_seen;
      reset   = 1'b0;
      read    = 1'b1;
      address = 32'h0;
      #12;
      chk("rst_busy", {31'h0, busywait}, 32'h0);
      chk("rst_memrd", {31'h0, mem_read}, 32'h0);
      chk("rst_maddr", {4'h0, mem_address}, 32'h0);
      chk("rst_data", readdata, 32'h0);
      read = 1'b0;
      @(negedge clock);
      reset = 1'b1;

      miss_chk("cold", 32'h0, 28'h0, 32'h00500093);
      hit_chk("hit4", 32'h4, 32'h00506113);
      hit_chk("hit8", 32'h8, 32'h00000013);
      hit_chk("hitC", 32'hC, 32'h00000013);

      miss_chk("conf80", 32'h80, 28'h8, 32'hC0DE0080);
      miss_chk("conf00", 32'h0, 28'h0, 32'h00500093);

      miss_chk("wrap70", 32'h70, 28'h7, 32'hC0DE0070);
      miss_chk("wrap80", 32'h80, 28'h8, 32'hC0DE0080);
      hit_chk("hit70", 32'h70, 32'hC0DE0070);
      hit_chk("hit80", 32'h80, 32'hC0DE0080);

      // Reset in the middle of a fill of 0x10.
      @(negedge clock);
      address = 32'h10;
      read    = 1'b1;
      @(negedge clock);
      @(negedge clock);
      chk("mid_memrd_pre", {31'h0, mem_read}, 32'h1);
      reset = 1'b0;
      #1;
      chk("mid_memrd", {31'h0, mem_read}, 32'h0);
      chk("mid_busy", {31'h0, busywait}, 32'h0);
      read = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      miss_chk("refill10", 32'h10, 28'h1, 32'hC0DE0010);

      // read low on a missing address: no stall, no fill.
      @(negedge clock);
      address = 32'h200;
      read    = 1'b0;
      mr_seen = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         if (mem_read || busywait) mr_seen++;
         @(negedge clock);
      end
      chk("noread_stall", mr_seen, 0);
      chk("noread_data", readdata, 32'h0);
      hit_chk("post_hit10", 32'h10, 32'hC0DE0010);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
